// File: rtl/nn_mem_sequencer.sv
// nn_mem_sequencer: learn/classify sequencer driving the kernel SRAM (KMEM), the dual-port weight SRAM (WMEM)
// and the conv/FC datapath strobes.
//   clk, rst (async, active-low)       : clock and reset
//   learn, classify, cls_done          : commands (sampled in IDLE) and datapath classify completion
//   KMEM_* / WMEM_*                    : SRAM address and active-low CSB/OEB/WEB (WEB held high)
//   k_ld/k_idx, w_ld/w_idx             : datapath load strobes, aligned to RD_LAT-delayed read data
//   cls_start, busy, done, err         : datapath start pulse and sequence status
// Optional macro CLS_TIMEOUT_EN adds a TIMEOUT-cycle watchdog on CLS_RUN.
module nn_mem_sequencer #(
   parameter int NUM_ADDR = 5,
   parameter int KWORDS   = 2,
   parameter int WWORDS   = 2,
   parameter int RD_LAT   = 1,
   parameter int TIMEOUT  = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                learn,
   input  logic                classify,
   input  logic                cls_done,
   output logic [NUM_ADDR-1:0] KMEM_ADD1,
   output logic                KMEM_CSB1,
   output logic                KMEM_OEB1,
   output logic                KMEM_WEB1,
   output logic [NUM_ADDR-1:0] WMEM_ADD1,
   output logic [NUM_ADDR-1:0] WMEM_ADD2,
   output logic                WMEM_CSB1,
   output logic                WMEM_CSB2,
   output logic                WMEM_OEB1,
   output logic                WMEM_OEB2,
   output logic                WMEM_WEB1,
   output logic                WMEM_WEB2,
   output logic                k_ld,
   output logic [NUM_ADDR-1:0] k_idx,
   output logic                w_ld,
   output logic [NUM_ADDR-1:0] w_idx,
   output logic                cls_start,
   output logic                busy,
   output logic                done,
   output logic                err
);
   typedef enum logic [2:0] {IDLE, LRD_K, LRD_W, DRAIN, CLS_RUN, FIN} state_t;

   if (KWORDS < 1 || KWORDS > (1 << NUM_ADDR)) begin : g_bad_kwords
      $error("KWORDS out of range");
   end
   if (WWORDS < 1 || WWORDS > (1 << (NUM_ADDR - 1))) begin : g_bad_wwords
      $error("WWORDS out of range");
   end
   if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
      $error("RD_LAT out of range");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("TIMEOUT out of range");
   end

   state_t              state, state_n;
   logic [31:0]         cnt, cnt_n;
   logic                learned;
   // classify-without-learn is flagged one cycle after sampling so err lands in cycle 1
   logic                err_pend, err_pend_n;
   logic                fin_err, fin_err_n;
   logic                kr, wr, busy_n, done_n, err_n, cs_n;
   logic [NUM_ADDR-1:0] kadd_n, wa1_n, wa2_n;
   // read strobes and indices delayed by the SRAM read latency
   logic [RD_LAT-1:0]   kv, wv;
   logic [NUM_ADDR-1:0] ki [RD_LAT];
   logic [NUM_ADDR-1:0] wi [RD_LAT];

   assign KMEM_WEB1 = 1'b1;
   assign WMEM_WEB1 = 1'b1;
   assign WMEM_WEB2 = 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         learned  <= 1'b0;
         err_pend <= 1'b0;
         fin_err  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         learned  <= learned | (state == FIN);
         err_pend <= err_pend_n;
         fin_err  <= fin_err_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt + 32'd1;
      fin_err_n  = fin_err;
      err_pend_n = 1'b0;
      case (state)
         IDLE: begin
            cnt_n     = '0;
            fin_err_n = 1'b0;
            if (learn) state_n = LRD_K;
            else if (classify && learned) state_n = CLS_RUN;
            else if (classify) err_pend_n = 1'b1;
         end
         LRD_K: if (cnt == 32'(KWORDS - 1)) begin
            state_n = LRD_W;
            cnt_n   = '0;
         end
         LRD_W: if (cnt == 32'(WWORDS - 1)) begin
            state_n = DRAIN;
            cnt_n   = '0;
         end
         DRAIN: if (cnt == 32'(RD_LAT - 1)) state_n = FIN;
         CLS_RUN: begin
`ifdef CLS_TIMEOUT_EN
            // cnt == 0 is the start cycle, whose cls_done is ignored; a late cls_done beats expiry
            if (cnt != '0 && cls_done) state_n = FIN;
            else if (cnt == 32'(TIMEOUT)) begin
               state_n   = FIN;
               fin_err_n = 1'b1;
            end
`else
            cnt_n = 32'd1;
            if (cnt != '0 && cls_done) state_n = FIN;
`endif
         end
         FIN: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      kr     = state == LRD_K;
      wr     = state == LRD_W;
      kadd_n = kr ? NUM_ADDR'(cnt) : KMEM_ADD1;
      wa1_n  = wr ? NUM_ADDR'(cnt << 1) : WMEM_ADD1;
      wa2_n  = wr ? NUM_ADDR'((cnt << 1) | 32'd1) : WMEM_ADD2;
      busy_n = state != IDLE;
      done_n = state == FIN && !fin_err;
      err_n  = err_pend || (state == FIN && fin_err);
      cs_n   = state == CLS_RUN && cnt == '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         KMEM_ADD1 <= '0;
         KMEM_CSB1 <= 1'b1;
         KMEM_OEB1 <= 1'b1;
         WMEM_ADD1 <= '0;
         WMEM_ADD2 <= '0;
         WMEM_CSB1 <= 1'b1;
         WMEM_CSB2 <= 1'b1;
         WMEM_OEB1 <= 1'b1;
         WMEM_OEB2 <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cls_start <= 1'b0;
         k_ld      <= 1'b0;
         k_idx     <= '0;
         w_ld      <= 1'b0;
         w_idx     <= '0;
         kv        <= '0;
         wv        <= '0;
         for (int j = 0; j < RD_LAT; j++) begin
            ki[j] <= '0;
            wi[j] <= '0;
         end
      end else begin
         KMEM_ADD1 <= kadd_n;
         KMEM_CSB1 <= !kr;
         KMEM_OEB1 <= !kr;
         WMEM_ADD1 <= wa1_n;
         WMEM_ADD2 <= wa2_n;
         WMEM_CSB1 <= !wr;
         WMEM_CSB2 <= !wr;
         WMEM_OEB1 <= !wr;
         WMEM_OEB2 <= !wr;
         busy      <= busy_n;
         done      <= done_n;
         err       <= err_n;
         cls_start <= cs_n;
         kv[0]     <= kr;
         wv[0]     <= wr;
         ki[0]     <= kadd_n;
         wi[0]     <= NUM_ADDR'(cnt);
         for (int j = 1; j < RD_LAT; j++) begin
            kv[j] <= kv[j-1];
            wv[j] <= wv[j-1];
            ki[j] <= ki[j-1];
            wi[j] <= wi[j-1];
         end
         k_ld <= kv[RD_LAT-1];
         w_ld <= wv[RD_LAT-1];
         if (kv[RD_LAT-1]) k_idx <= ki[RD_LAT-1];
         if (wv[RD_LAT-1]) w_idx <= wi[RD_LAT-1];
      end
   end
endmodule

// File: tb/tb_nn_mem_sequencer.sv
// tb_nn_mem_sequencer: table-driven cycle checks plus an SRAM/datapath scoreboard for nn_mem_sequencer.
module tb_nn_mem_sequencer;
   logic       clk = 1'b0, rst = 1'b0, learn = 1'b0, classify = 1'b0, cls_done = 1'b0;
   logic [4:0] KMEM_ADD1, WMEM_ADD1, WMEM_ADD2, k_idx, w_idx;
   logic       KMEM_CSB1, KMEM_OEB1, KMEM_WEB1, WMEM_CSB1, WMEM_CSB2, WMEM_OEB1, WMEM_OEB2, WMEM_WEB1, WMEM_WEB2;
   logic       k_ld, w_ld, cls_start, busy, done, err;
   int         n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   nn_mem_sequencer #(.NUM_ADDR(5), .KWORDS(2), .WWORDS(2), .RD_LAT(1), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .learn(learn), .classify(classify), .cls_done(cls_done),
      .KMEM_ADD1(KMEM_ADD1), .KMEM_CSB1(KMEM_CSB1), .KMEM_OEB1(KMEM_OEB1), .KMEM_WEB1(KMEM_WEB1),
      .WMEM_ADD1(WMEM_ADD1), .WMEM_ADD2(WMEM_ADD2), .WMEM_CSB1(WMEM_CSB1), .WMEM_CSB2(WMEM_CSB2),
      .WMEM_OEB1(WMEM_OEB1), .WMEM_OEB2(WMEM_OEB2), .WMEM_WEB1(WMEM_WEB1), .WMEM_WEB2(WMEM_WEB2),
      .k_ld(k_ld), .k_idx(k_idx), .w_ld(w_ld), .w_idx(w_idx),
      .cls_start(cls_start), .busy(busy), .done(done), .err(err)
   );

   // SRAM models (one-cycle read latency): kernel word a holds a, weight word j holds 0x10+j
   logic [7:0]  kr_data = 8'h0, wd1 = 8'h0, wd2 = 8'h0;
   logic [7:0]  cap_k [64];
   logic [15:0] cap_w [64];
   int          ncap_k = 0, ncap_w = 0;
   always @(posedge clk) begin
      if (!KMEM_CSB1 && !KMEM_OEB1) kr_data <= 8'(KMEM_ADD1);
      if (!WMEM_CSB1 && !WMEM_OEB1) wd1 <= 8'h10 + 8'(WMEM_ADD1);
      if (!WMEM_CSB2 && !WMEM_OEB2) wd2 <= 8'h10 + 8'(WMEM_ADD2);
      if (k_ld && ncap_k < 64) begin
         cap_k[ncap_k] <= kr_data;
         ncap_k <= ncap_k + 1;
      end
      if (w_ld && ncap_w < 64) begin
         cap_w[ncap_w] <= {wd1, wd2};
         ncap_w <= ncap_w + 1;
      end
   end

   typedef struct {
      logic l, c, d, busy, done, err, cs, kld;
      logic [4:0] kidx;
      logic wld;
      logic [4:0] widx;
      logic kcsb;
      logic [4:0] kadd;
      logic wcsb;
      logic [4:0] wa1, wa2;
   } rec_t;

   rec_t        tbl[$];
   logic [7:0]  exp_k[$];
   logic [15:0] exp_w[$];

   function automatic rec_t mk(input logic l, c, d, b, dn, e, s, kl, input logic [4:0] ki, input logic wl,
                               input logic [4:0] wi, input logic kc, input logic [4:0] ka, input logic wc,
                               input logic [4:0] a1, a2);
      rec_t r;
      r.l = l; r.c = c; r.d = d; r.busy = b; r.done = dn; r.err = e; r.cs = s; r.kld = kl; r.kidx = ki;
      r.wld = wl; r.widx = wi; r.kcsb = kc; r.kadd = ka; r.wcsb = wc; r.wa1 = a1; r.wa2 = a2;
      return r;
   endfunction

   // idle-memory row with addresses left at 1 / 2,3 from the last learn
   function automatic rec_t cr(input logic l, c, d, b, dn, e, s);
      return mk(l, c, d, b, dn, e, s, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 5'd2, 5'd3);
   endfunction

   task automatic add_learn(input logic both, input logic [4:0] pk, p1, p2);
      tbl.push_back(mk(1, both, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk, 1, p1, p2));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, p1, p2));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, p1, p2));
      tbl.push_back(mk(0, both, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 2, 3));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 3));
      tbl.push_back(cr(0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(cr(0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(cr(0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check_row(input int i, input rec_t r);
      chk($sformatf("row%0d busy", i), 16'(busy), 16'(r.busy));
      chk($sformatf("row%0d done", i), 16'(done), 16'(r.done));
      chk($sformatf("row%0d err", i), 16'(err), 16'(r.err));
      chk($sformatf("row%0d cls_start", i), 16'(cls_start), 16'(r.cs));
      chk($sformatf("row%0d k_ld", i), 16'(k_ld), 16'(r.kld));
      chk($sformatf("row%0d w_ld", i), 16'(w_ld), 16'(r.wld));
      chk($sformatf("row%0d kcsb/oeb", i), 16'({KMEM_CSB1, KMEM_OEB1}), 16'({r.kcsb, r.kcsb}));
      chk($sformatf("row%0d wcsb/oeb", i), 16'({WMEM_CSB1, WMEM_CSB2, WMEM_OEB1, WMEM_OEB2}), 16'({4{r.wcsb}}));
      chk($sformatf("row%0d web", i), 16'({KMEM_WEB1, WMEM_WEB1, WMEM_WEB2}), 16'h7);
      chk($sformatf("row%0d kadd", i), 16'(KMEM_ADD1), 16'(r.kadd));
      chk($sformatf("row%0d wadd", i), 16'({WMEM_ADD1, WMEM_ADD2}), 16'({r.wa1, r.wa2}));
      if (r.kld) chk($sformatf("row%0d k_idx", i), 16'(k_idx), 16'(r.kidx));
      if (r.wld) chk($sformatf("row%0d w_idx", i), 16'(w_idx), 16'(r.widx));
   endtask

   initial begin
      int n0, m0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy/done/err/cs", 16'({busy, done, err, cls_start}), 16'h0);
      chk("reset k_ld/w_ld", 16'({k_ld, w_ld}), 16'h0);
      chk("reset csb/oeb/web", 16'({KMEM_CSB1, KMEM_OEB1, KMEM_WEB1, WMEM_CSB1, WMEM_CSB2,
                                   WMEM_OEB1, WMEM_OEB2, WMEM_WEB1, WMEM_WEB2}), 16'h1ff);
      chk("reset addr", 16'({KMEM_ADD1, WMEM_ADD1, WMEM_ADD2}), 16'h0);
      chk("reset idx", 16'({k_idx, w_idx}), 16'h0);
      rst = 1'b1;

      // classify before any learn: err in cycle 1 only
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      add_learn(1'b0, 5'd0, 5'd0, 5'd0);
      // classify, cls_done sampled in cycle 5
      tbl.push_back(cr(0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(cr(0, 0, 0, 1, 0, 0, 1));
      tbl.push_back(cr(0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(cr(0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(cr(0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(cr(0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(cr(0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(cr(0, 0, 0, 0, 0, 0, 0));
      // cls_done in IDLE ignored; cls_done in cycle 1 ignored, honoured in cycle 2
      tbl.push_back(cr(0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(cr(0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(cr(0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(cr(0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(cr(0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(cr(0, 0, 0, 0, 0, 0, 0));
      // learn and classify together, plus a classify pulse while busy
      add_learn(1'b1, 5'd1, 5'd2, 5'd3);

      foreach (tbl[i]) begin
         learn = tbl[i].l;
         classify = tbl[i].c;
         cls_done = tbl[i].d;
         if (tbl[i].l) begin
            exp_k.push_back(8'h00);
            exp_k.push_back(8'h01);
            exp_w.push_back(16'h1011);
            exp_w.push_back(16'h1213);
         end
         step();
         check_row(i, tbl[i]);
      end
      learn = 1'b0;
      classify = 1'b0;
      cls_done = 1'b0;

      chk("k capture count", 16'(ncap_k), 16'(exp_k.size()));
      chk("w capture count", 16'(ncap_w), 16'(exp_w.size()));
      for (int i = 0; exp_k.size() > 0; i++) begin
         logic [7:0] e;
         e = exp_k.pop_front();
         if (i < ncap_k) chk($sformatf("k data %0d", i), 16'(cap_k[i]), 16'(e));
      end
      for (int i = 0; exp_w.size() > 0; i++) begin
         logic [15:0] e;
         e = exp_w.pop_front();
         if (i < ncap_w) chk($sformatf("w data %0d", i), cap_w[i], e);
      end

      // reset asserted in cycle 3 of a learn
      learn = 1'b1;
      step();
      learn = 1'b0;
      repeat (3) step();
      n0 = ncap_k;
      m0 = ncap_w;
      rst = 1'b0;
      #1;
      chk("midrst csb/oeb", 16'({KMEM_CSB1, KMEM_OEB1, WMEM_CSB1, WMEM_CSB2, WMEM_OEB1, WMEM_OEB2}), 16'h3f);
      chk("midrst busy", 16'(busy), 16'h0);
      chk("midrst ld", 16'({k_ld, w_ld}), 16'h0);
      chk("midrst kadd", 16'(KMEM_ADD1), 16'h0);
      repeat (2) step();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("post-rst ld c%0d", c), 16'({k_ld, w_ld, busy}), 16'h0);
      end
      chk("post-rst k captures", 16'(ncap_k), 16'(n0));
      chk("post-rst w captures", 16'(ncap_w), 16'(m0));
      classify = 1'b1;
      step();
      classify = 1'b0;
      step();
      chk("post-rst classify err", 16'(err), 16'h1);
      chk("post-rst classify cs/busy", 16'({cls_start, busy}), 16'h0);
      chk("post-rst classify csb", 16'({KMEM_CSB1, WMEM_CSB1, WMEM_CSB2}), 16'h7);

`ifdef CLS_TIMEOUT_EN
      learn = 1'b1;
      step();
      learn = 1'b0;
      repeat (8) step();
      classify = 1'b1;
      step();
      classify = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         step();
         chk($sformatf("tmo err c%0d", c), 16'(err), 16'(c == 10));
         chk($sformatf("tmo done c%0d", c), 16'(done), 16'h0);
         chk($sformatf("tmo busy c%0d", c), 16'(busy), 16'(c <= 10));
      end
      classify = 1'b1;
      step();
      classify = 1'b0;
      step();
      chk("tmo retry cls_start", 16'(cls_start), 16'h1);
      cls_done = 1'b1;
      step();
      cls_done = 1'b0;
      step();
      chk("tmo retry done", 16'({done, err}), 16'h2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
